// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array tile sequencer: state encoding,
// skew length and the power-of-two ceiling divide used for tile counts.
package sa_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_FEED = 3'd2,
      ST_WB   = 3'd3,
      ST_DONE = 3'd4
   } sa_state_e;

   // Extra feed steps needed for operands to ripple through the skewed array.
   function automatic int sa_skew(input int rows, input int cols);
      return rows + cols - 2;
   endfunction

   function automatic int unsigned sa_ceil_div_pow2(input int unsigned val,
                                                    input int unsigned lg2);
      return (val + (32'd1 << lg2) - 32'd1) >> lg2;
   endfunction

endpackage

// File: rtl/sa_edge_mask.sv
// Valid-lane mask for one array dimension; only the last tile of a dimension
// may be partial, in which case the low (size mod WIDTH) lanes are enabled.
module sa_edge_mask #(
   parameter int WIDTH      = 4,
   parameter int WIDTH_LOG2 = 2
) (
   input  logic                  en,
   input  logic                  is_edge,
   input  logic [WIDTH_LOG2-1:0] rem,
   output logic [WIDTH-1:0]      mask
);

   always_comb begin
      mask = '0;
      for (int i = 0; i < WIDTH; i++) begin
         mask[i] = en & (~is_edge | (rem == '0) | (i < int'(rem)));
      end
   end

endmodule

// File: rtl/sa_tile_sequencer.sv
// Sequences an MxKxN matrix multiply over a ROWS x COLS systolic array tile by
// tile: operand feed with skew, accumulator clear, writeback handshake.
//
// state   | meaning
// IDLE    | waiting for START, outputs quiet, CYCLES_out holds last run
// LOAD    | one cycle: tile counts computed, zero-size runs skip to DONE
// FEED    | operand feed for current tile, frozen while STALL=1
// WB      | tile result offered, waits for WB_READY_in
// DONE    | one-cycle completion pulse
module sa_tile_sequencer
   import sa_pkg::*;
#(
   parameter int PE_ARRAY_NUM_ROWS      = 4,
   parameter int PE_ARRAY_NUM_ROWS_LOG2 = 2,
   parameter int PE_ARRAY_NUM_COLS      = 4,
   parameter int PE_ARRAY_NUM_COLS_LOG2 = 2,
   parameter int MAX_M_SIZE_LOG2        = 9,
   parameter int MAX_K_SIZE_LOG2        = 9,
   parameter int MAX_N_SIZE_LOG2        = 9,
   parameter int CYCLE_CNT_BWIDTH       = 32
) (
   input  logic                          CLK,
   input  logic                          RSTn,
   input  logic                          START,
   input  logic                          STALL,
   input  logic [MAX_M_SIZE_LOG2-1:0]    M_SIZE_in,
   input  logic [MAX_K_SIZE_LOG2-1:0]    K_SIZE_in,
   input  logic [MAX_N_SIZE_LOG2-1:0]    N_SIZE_in,
   output logic                          FEED_EN_out,
   output logic [MAX_K_SIZE_LOG2:0]      FEED_K_out,
   output logic                          ACC_CLR_out,
   output logic [MAX_M_SIZE_LOG2-1:0]    TILE_M_out,
   output logic [MAX_N_SIZE_LOG2-1:0]    TILE_N_out,
   output logic [PE_ARRAY_NUM_ROWS-1:0]  ROW_MASK_out,
   output logic [PE_ARRAY_NUM_COLS-1:0]  COL_MASK_out,
   output logic                          WB_VALID_out,
   input  logic                          WB_READY_in,
   output logic                          BUSY_out,
   output logic                          IS_FINISHED_out,
   output logic [CYCLE_CNT_BWIDTH-1:0]   CYCLES_out
);

   localparam int MW   = MAX_M_SIZE_LOG2;
   localparam int KW   = MAX_K_SIZE_LOG2 + 1;
   localparam int NW   = MAX_N_SIZE_LOG2;
   localparam int RL   = PE_ARRAY_NUM_ROWS_LOG2;
   localparam int CL   = PE_ARRAY_NUM_COLS_LOG2;
   localparam int SKEW = sa_skew(PE_ARRAY_NUM_ROWS, PE_ARRAY_NUM_COLS);

   sa_state_e state, state_nxt;

   logic [MW-1:0]               m_size;
   logic [MAX_K_SIZE_LOG2-1:0]  k_size;
   logic [NW-1:0]               n_size;
   logic [MW:0]                 m_tiles, m_idx;
   logic [NW:0]                 n_tiles, n_idx;
   logic [KW-1:0]               k_step;
   logic [KW-1:0]               feed_last;
   logic [CYCLE_CNT_BWIDTH-1:0] cycle_cnt;

   logic size_zero, feed_done, m_last, n_last, tile_last, in_tile;

   assign size_zero = (m_size == '0) | (k_size == '0) | (n_size == '0);
   assign feed_last = {1'b0, k_size} + KW'(SKEW) - KW'(1);
   assign feed_done = (k_step == feed_last);
   assign m_last    = (m_idx == m_tiles - (MW+1)'(1));
   assign n_last    = (n_idx == n_tiles - (NW+1)'(1));
   assign tile_last = m_last & n_last;

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (START) state_nxt = ST_LOAD;
         ST_LOAD: state_nxt = size_zero ? ST_DONE : ST_FEED;
         ST_FEED: if (!STALL && feed_done) state_nxt = ST_WB;
         ST_WB:   if (WB_READY_in) state_nxt = tile_last ? ST_DONE : ST_FEED;
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      FEED_EN_out     = 1'b0;
      FEED_K_out      = '0;
      ACC_CLR_out     = 1'b0;
      WB_VALID_out    = 1'b0;
      BUSY_out        = 1'b0;
      IS_FINISHED_out = 1'b0;
      TILE_M_out      = '0;
      TILE_N_out      = '0;
      in_tile         = 1'b0;
      case (state)
         ST_LOAD: BUSY_out = 1'b1;
         ST_FEED: begin
            BUSY_out    = 1'b1;
            in_tile     = 1'b1;
            FEED_EN_out = ~STALL;
            FEED_K_out  = k_step;
            // A stalled step 0 drops the clear; it reappears when feeding resumes.
            ACC_CLR_out = ~STALL & (k_step == '0);
            TILE_M_out  = MW'({m_idx, {RL{1'b0}}});
            TILE_N_out  = NW'({n_idx, {CL{1'b0}}});
         end
         ST_WB: begin
            BUSY_out     = 1'b1;
            in_tile      = 1'b1;
            WB_VALID_out = 1'b1;
            TILE_M_out   = MW'({m_idx, {RL{1'b0}}});
            TILE_N_out   = NW'({n_idx, {CL{1'b0}}});
         end
         ST_DONE: begin
            BUSY_out        = 1'b1;
            IS_FINISHED_out = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         m_size  <= '0;
         k_size  <= '0;
         n_size  <= '0;
         m_tiles <= '0;
         n_tiles <= '0;
         m_idx   <= '0;
         n_idx   <= '0;
         k_step  <= '0;
      end else begin
         case (state)
            ST_IDLE: if (START) begin
               m_size <= M_SIZE_in;
               k_size <= K_SIZE_in;
               n_size <= N_SIZE_in;
            end
            ST_LOAD: begin
               m_tiles <= (MW+1)'(sa_ceil_div_pow2(32'(m_size), RL));
               n_tiles <= (NW+1)'(sa_ceil_div_pow2(32'(n_size), CL));
               m_idx   <= '0;
               n_idx   <= '0;
               k_step  <= '0;
            end
            ST_FEED: if (!STALL) k_step <= feed_done ? '0 : k_step + KW'(1);
            ST_WB: if (WB_READY_in && !tile_last) begin
               if (n_last) begin
                  n_idx <= '0;
                  m_idx <= m_idx + (MW+1)'(1);
               end else begin
                  n_idx <= n_idx + (NW+1)'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Counts every non-idle cycle, stalls included; holds through IDLE.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         cycle_cnt <= '0;
      end else if (state == ST_IDLE) begin
         if (START) cycle_cnt <= '0;
      end else if (cycle_cnt != '1) begin
         cycle_cnt <= cycle_cnt + CYCLE_CNT_BWIDTH'(1);
      end
   end

   assign CYCLES_out = cycle_cnt;

   sa_edge_mask #(
      .WIDTH      (PE_ARRAY_NUM_ROWS),
      .WIDTH_LOG2 (RL)
   ) u_row_mask (
      .en      (in_tile),
      .is_edge (m_last),
      .rem     (m_size[RL-1:0]),
      .mask    (ROW_MASK_out)
   );

   sa_edge_mask #(
      .WIDTH      (PE_ARRAY_NUM_COLS),
      .WIDTH_LOG2 (CL)
   ) u_col_mask (
      .en      (in_tile),
      .is_edge (n_last),
      .rem     (n_size[CL-1:0]),
      .mask    (COL_MASK_out)
   );

endmodule
